mfp_adc_max10_arbiter: RTL and testbench

Shares the single MAX10 ADC sequencer, with its Avalon-ST command/response interface, between N_REQ independent requesters, for example the register-driven measurement core and a background sampler. Each requester submits one channel-conversion request. The arbiter grants round-robin and allows exactly one conversion in flight. It routes the response back to the owner and reports a timeout if the ADC never answers. It sits between the requesters and the adc_core command/response ports.

---
 rtl/mfp_adc_max10_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mfp_adc_max10_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfp_adc_max10_arbiter.sv
// Round-robin arbiter sharing one MAX10 ADC sequencer among N_REQ requesters.
// Allows a single conversion in flight, routes the response to its owner and forces an error completion on timeout.
module mfp_adc_max10_arbiter #(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic               CLK,
  input  logic               RESETn,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [5*N_REQ-1:0] req_channel,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [11:0]        rsp_data,
  output logic [4:0]         rsp_channel,
  output logic               rsp_error,
  output logic               busy,
  output logic               ADC_C_Valid,
  output logic [4:0]         ADC_C_Channel,
  output logic               ADC_C_SOP,
  output logic               ADC_C_EOP,
  input  logic               ADC_C_Ready,
  input  logic               ADC_R_Valid,
  input  logic [4:0]         ADC_R_Channel,
  input  logic [11:0]        ADC_R_Data
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_WAIT} state_e;

  state_e           state_q, state_d;
  logic [GW-1:0]    last_q, last_d;
  logic [GW-1:0]    owner_q, owner_d;
  logic [4:0]       chan_q, chan_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] req_ready_q, req_ready_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [11:0]      rsp_data_q, rsp_data_d;
  logic [4:0]       rsp_channel_q, rsp_channel_d;
  logic             rsp_error_q, rsp_error_d;
  logic             busy_q, busy_d;
  logic             cvalid_q, cvalid_d;

  logic             any_req;
  logic [GW-1:0]    pick;
  logic [4:0]       pick_chan;
  logic             timeout_hit;

  // Round-robin pick: scanning from farthest to nearest so the first set index after last_q wins.
  always_comb begin
    int unsigned idx;
    logic [GW-1:0] cand;
    any_req = 1'b0;
    pick    = '0;
    idx     = 0;
    cand    = '0;
    for (int unsigned k = N_REQ; k >= 1; k--) begin
      idx  = (32'(last_q) + k) % N_REQ;
      cand = GW'(idx);
      if (req_valid[cand]) begin
        any_req = 1'b1;
        pick    = cand;
      end
    end
  end

  always_comb begin
    pick_chan = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (GW'(i) == pick) pick_chan = req_channel[5*i +: 5];
    end
  end

  always_comb begin
    timeout_hit   = (cnt_q == CW'(TIMEOUT - 1));
    state_d       = state_q;
    last_d        = last_q;
    owner_d       = owner_q;
    chan_d        = chan_q;
    cnt_d         = cnt_q;
    req_ready_d   = '0;
    rsp_valid_d   = '0;
    rsp_data_d    = rsp_data_q;
    rsp_channel_d = rsp_channel_q;
    rsp_error_d   = rsp_error_q;
    busy_d        = busy_q;
    cvalid_d      = cvalid_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d           = pick;
          chan_d            = pick_chan;
          last_d            = pick;
          req_ready_d[pick] = 1'b1;
          cvalid_d          = 1'b1;
          cnt_d             = '0;
          busy_d            = 1'b1;
          state_d           = ST_CMD;
        end
      end
      ST_CMD: begin
        cnt_d = cnt_q + CW'(1);
        // A response cannot be legal before the command is taken, so only the timeout can end this phase early.
        if (timeout_hit) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_error_d          = 1'b1;
          rsp_data_d           = '0;
          rsp_channel_d        = chan_q;
          cvalid_d             = 1'b0;
          busy_d               = 1'b0;
          state_d              = ST_IDLE;
        end else if (ADC_C_Ready) begin
          cvalid_d = 1'b0;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (ADC_R_Valid) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_data_d           = ADC_R_Data;
          rsp_channel_d        = ADC_R_Channel;
          rsp_error_d          = (ADC_R_Channel != chan_q);
          busy_d               = 1'b0;
          state_d              = ST_IDLE;
        end else if (timeout_hit) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_error_d          = 1'b1;
          rsp_data_d           = '0;
          rsp_channel_d        = chan_q;
          cvalid_d             = 1'b0;
          busy_d               = 1'b0;
          state_d              = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q       <= ST_IDLE;
      last_q        <= GW'(N_REQ - 1);
      owner_q       <= '0;
      chan_q        <= '0;
      cnt_q         <= '0;
      req_ready_q   <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      rsp_channel_q <= '0;
      rsp_error_q   <= 1'b0;
      busy_q        <= 1'b0;
      cvalid_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      owner_q       <= owner_d;
      chan_q        <= chan_d;
      cnt_q         <= cnt_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_channel_q <= rsp_channel_d;
      rsp_error_q   <= rsp_error_d;
      busy_q        <= busy_d;
      cvalid_q      <= cvalid_d;
    end
  end

  // Single-beat commands: SOP and EOP are the valid flop itself.
  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_channel   = rsp_channel_q;
  assign rsp_error     = rsp_error_q;
  assign busy          = busy_q;
  assign ADC_C_Valid   = cvalid_q;
  assign ADC_C_Channel = chan_q;
  assign ADC_C_SOP     = cvalid_q;
  assign ADC_C_EOP     = cvalid_q;

endmodule

// File: tb/tb_mfp_adc_max10_arbiter.sv
// Self-checking bench for mfp_adc_max10_arbiter: transaction-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mfp_adc_max10_arbiter;

  localparam int N_REQ   = 2;
  localparam int TIMEOUT = 16;

  logic               CLK = 1'b0;
  logic               RESETn;
  logic [N_REQ-1:0]   req_valid;
  logic [5*N_REQ-1:0] req_channel;
  logic [N_REQ-1:0]   req_ready, rsp_valid;
  logic [11:0]        rsp_data;
  logic [4:0]         rsp_channel;
  logic               rsp_error, busy;
  logic               ADC_C_Valid, ADC_C_SOP, ADC_C_EOP, ADC_C_Ready;
  logic [4:0]         ADC_C_Channel;
  logic               ADC_R_Valid;
  logic [4:0]         ADC_R_Channel;
  logic [11:0]        ADC_R_Data;

  int errors = 0;
  int checks = 0;

  mfp_adc_max10_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .req_valid(req_valid), .req_channel(req_channel), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_channel(rsp_channel),
    .rsp_error(rsp_error), .busy(busy),
    .ADC_C_Valid(ADC_C_Valid), .ADC_C_Channel(ADC_C_Channel),
    .ADC_C_SOP(ADC_C_SOP), .ADC_C_EOP(ADC_C_EOP), .ADC_C_Ready(ADC_C_Ready),
    .ADC_R_Valid(ADC_R_Valid), .ADC_R_Channel(ADC_R_Channel), .ADC_R_Data(ADC_R_Data)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction tracked by its age since issue.
  int               m_last, m_owner, m_age, m_idx;
  bit               m_busy, m_acc;
  logic [4:0]       m_ch;
  logic [N_REQ-1:0] e_ready, e_rv;
  logic [11:0]      e_data;
  logic [4:0]       e_rch, e_cch;
  logic             e_err, e_cv, e_busy;

  always @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      m_last = N_REQ - 1; m_owner = 0; m_age = 0; m_busy = 0; m_acc = 0; m_ch = '0;
      e_ready = '0; e_rv = '0; e_data = '0; e_rch = '0; e_cch = '0;
      e_err = 1'b0; e_cv = 1'b0; e_busy = 1'b0;
    end else begin
      e_ready = '0;
      e_rv    = '0;
      if (!m_busy) begin
        for (int k = 1; k <= N_REQ; k++) begin
          m_idx = (m_last + k) % N_REQ;
          if (!m_busy && req_valid[m_idx]) begin
            m_owner = m_idx;
            m_busy  = 1;
          end
        end
        if (m_busy) begin
          m_last = m_owner;
          m_ch   = req_channel[5*m_owner +: 5];
          m_age  = 0;
          m_acc  = 0;
          e_ready[m_owner] = 1'b1;
          e_cv  = 1'b1;
          e_cch = m_ch;
        end
      end else begin
        m_age++;
        if (m_acc && ADC_R_Valid) begin
          e_rv[m_owner] = 1'b1;
          e_data = ADC_R_Data; e_rch = ADC_R_Channel; e_err = (ADC_R_Channel != m_ch);
          m_busy = 0;
        end else if (m_age == TIMEOUT) begin
          e_rv[m_owner] = 1'b1;
          e_data = '0; e_rch = m_ch; e_err = 1'b1; e_cv = 1'b0;
          m_busy = 0;
        end else if (!m_acc && ADC_C_Ready) begin
          m_acc = 1;
          e_cv  = 1'b0;
        end
      end
      e_busy = m_busy;
    end
  end

  always @(posedge CLK) begin
    #1;
    check("m_req_ready", 32'(req_ready), 32'(e_ready));
    check("m_rsp_valid", 32'(rsp_valid), 32'(e_rv));
    check("m_rsp_data", 32'(rsp_data), 32'(e_data));
    check("m_rsp_channel", 32'(rsp_channel), 32'(e_rch));
    check("m_rsp_error", 32'(rsp_error), 32'(e_err));
    check("m_busy", 32'(busy), 32'(e_busy));
    check("m_c_valid", 32'(ADC_C_Valid), 32'(e_cv));
    check("m_c_sop", 32'(ADC_C_SOP), 32'(e_cv));
    check("m_c_eop", 32'(ADC_C_EOP), 32'(e_cv));
    check("m_c_channel", 32'(ADC_C_Channel), 32'(e_cch));
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESETn = 1'b0;
    tick();
    tick();
    RESETn = 1'b1;
  endtask

  task automatic wait_grant(output logic [N_REQ-1:0] got);
    bit seen = 0;
    got = '0;
    for (int n = 0; n < 50 && !seen; n++) begin
      tick();
      if (req_ready != '0) begin
        seen = 1;
        got  = req_ready;
      end
    end
    check("grant_wait", 32'(seen), 32'(1));
  endtask

  initial begin
    logic [N_REQ-1:0] got;
    RESETn = 1'b0; req_valid = '0; req_channel = '0; ADC_C_Ready = 1'b0;
    ADC_R_Valid = 1'b0; ADC_R_Channel = '0; ADC_R_Data = '0;
    do_reset();
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_c_valid", 32'(ADC_C_Valid), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));

    // Contention: both held, grants alternate starting at requester 0
    req_valid = 2'b11; req_channel = {5'd5, 5'd1};
    for (int g = 0; g < 4; g++) begin
      wait_grant(got);
      check("rr_grant", 32'(got), (g % 2) ? 32'h2 : 32'h1);
      check("rr_c_channel", 32'(ADC_C_Channel), (g % 2) ? 32'd5 : 32'd1);
      ADC_C_Ready = 1'b1;
      tick();
      ADC_C_Ready = 1'b0; ADC_R_Valid = 1'b1; ADC_R_Channel = ADC_C_Channel;
      ADC_R_Data = 12'(12'h100 + g);
      tick();
      ADC_R_Valid = 1'b0;
      check("rr_rsp_valid", 32'(rsp_valid), (g % 2) ? 32'h2 : 32'h1);
      check("rr_rsp_data", 32'(rsp_data), 32'h100 + 32'(g));
    end
    req_valid = '0;
    tick();

    // Single request, ADC accepts after 2 cycles
    do_reset();
    req_valid = 2'b01; req_channel = {5'd0, 5'd3};
    tick();
    check("t1_req_ready", 32'(req_ready), 32'h1);
    check("t1_c_valid", 32'(ADC_C_Valid), 32'd1);
    check("t1_c_channel", 32'(ADC_C_Channel), 32'd3);
    req_valid = '0;
    tick();
    check("t1_c_valid_held", 32'(ADC_C_Valid), 32'd1);
    check("t1_req_ready_pulse", 32'(req_ready), 32'h0);
    ADC_C_Ready = 1'b1;
    tick();
    check("t1_c_valid_drop", 32'(ADC_C_Valid), 32'd0);
    ADC_C_Ready = 1'b0; ADC_R_Valid = 1'b1; ADC_R_Channel = 5'd3; ADC_R_Data = 12'hA5C;
    tick();
    ADC_R_Valid = 1'b0;
    check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    check("t1_rsp_data", 32'(rsp_data), 32'hA5C);
    check("t1_rsp_channel", 32'(rsp_channel), 32'd3);
    check("t1_rsp_error", 32'(rsp_error), 32'd0);
    tick();
    check("t1_rsp_hold", 32'(rsp_data), 32'hA5C);

    // Timeout with ADC_C_Ready low
    req_valid = 2'b01; req_channel = {5'd0, 5'd9};
    tick();
    check("t3_c_valid", 32'(ADC_C_Valid), 32'd1);
    req_valid = '0;
    for (int n = 0; n < TIMEOUT - 1; n++) tick();
    check("t3_no_early_rsp", 32'(rsp_valid), 32'h0);
    tick();
    check("t3_rsp_valid", 32'(rsp_valid), 32'h1);
    check("t3_rsp_error", 32'(rsp_error), 32'd1);
    check("t3_rsp_data", 32'(rsp_data), 32'h0);
    check("t3_rsp_channel", 32'(rsp_channel), 32'd9);
    check("t3_c_valid_off", 32'(ADC_C_Valid), 32'd0);
    check("t3_busy_off", 32'(busy), 32'd0);

    // Response on the timeout edge: mismatch then match
    for (int r = 0; r < 2; r++) begin
      req_valid = 2'b10; req_channel = {5'd2, 5'd0};
      tick();
      check("t4_req_ready", 32'(req_ready), 32'h2);
      req_valid = '0; ADC_C_Ready = 1'b1;
      tick();
      ADC_C_Ready = 1'b0;
      for (int n = 0; n < TIMEOUT - 2; n++) tick();
      check("t4_no_early_rsp", 32'(rsp_valid), 32'h0);
      ADC_R_Valid = 1'b1; ADC_R_Channel = r ? 5'd2 : 5'd7; ADC_R_Data = r ? 12'h7E1 : 12'h3C3;
      tick();
      ADC_R_Valid = 1'b0;
      check("t4_rsp_valid", 32'(rsp_valid), 32'h2);
      check("t4_rsp_error", 32'(rsp_error), r ? 32'd0 : 32'd1);
      check("t4_rsp_channel", 32'(rsp_channel), r ? 32'd2 : 32'd7);
      check("t4_rsp_data", 32'(rsp_data), r ? 32'h7E1 : 32'h3C3);
      tick();
    end

    // Asynchronous reset while waiting for the ADC
    req_valid = 2'b01; req_channel = {5'd0, 5'd4};
    tick();
    req_valid = '0; ADC_C_Ready = 1'b1;
    tick();
    ADC_C_Ready = 1'b0;
    tick();
    check("t5_busy_before", 32'(busy), 32'd1);
    #2 RESETn = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_c_channel", 32'(ADC_C_Channel), 32'd0);
    check("t5_rsp_data", 32'(rsp_data), 32'd0);
    check("t5_rsp_channel", 32'(rsp_channel), 32'd0);
    check("t5_c_valid", 32'(ADC_C_Valid), 32'd0);
    tick();
    RESETn = 1'b1;
    ADC_R_Valid = 1'b1; ADC_R_Channel = 5'd4; ADC_R_Data = 12'hFFF;
    tick();
    ADC_R_Valid = 1'b0;
    check("t5_stray_rsp", 32'(rsp_valid), 32'h0);
    req_valid = 2'b11; req_channel = {5'd6, 5'd8};
    tick();
    check("t5_first_grant", 32'(req_ready), 32'h1);
    check("t5_first_channel", 32'(ADC_C_Channel), 32'd8);
    req_valid = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, limit 100000 expected earlier end");
    $fatal(1, "watchdog");
  end

endmodule
